prescaler_prog: RTL and testbench

Parametrised, runtime-programmable successor to the fixed-ratio prescaler. It provides CHANNELS independent dividers off the main clock.
- Each channel has a divisor register loaded through a valid/ready config port.
- Each channel produces a one-cycle clock-enable tick and a near-50% square output.
- A global sync input phase-aligns all channels.
- It feeds the clock's timekeeping, display-multiplex and blink logic.

---
 rtl/prescaler_prog.sv | 142 ++++++++++++++
 tb/tb_prescaler_prog.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/prescaler_prog.sv
// Runtime-programmable multi-channel clock prescaler: per-channel tick and square output.
// Optional one-shot mode is compiled in with `define PRESCALER_ONESHOT_EN.
module prescaler_prog #(
  parameter int MAIN_CLOCK = 50_000_000,
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 32,
  parameter int RESET_DIV  = MAIN_CLOCK / 1000,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic [CHANNELS-1:0] ch_en,
`ifdef PRESCALER_ONESHOT_EN
  input  logic [CHANNELS-1:0] ch_oneshot,
`endif
  input  logic                sync,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clk_out
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_PEND = 1'b1;
  localparam logic [CNT_W-1:0] RESET_DIV_W = CNT_W'(RESET_DIV);
  localparam logic [CH_W:0]    CH_LIM      = (CH_W + 1)'(CHANNELS);

  logic [CNT_W-1:0]    cnt_q [CHANNELS];
  logic [CNT_W-1:0]    cnt_d [CHANNELS];
  logic [CNT_W-1:0]    div_q [CHANNELS];
  logic [CNT_W-1:0]    div_d [CHANNELS];
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] clk_q, clk_d;
  logic [CHANNELS-1:0] done_q, done_d;
  logic [CHANNELS-1:0] wrap, apply_ch, oneshot;
  logic                state_q, state_d;
  logic [CH_W-1:0]     pend_ch_q, pend_ch_d;
  logic [CNT_W-1:0]    pend_div_q, pend_div_d;
  logic                err_q, err_d;

`ifdef PRESCALER_ONESHOT_EN
  assign oneshot = ch_oneshot;
`else
  assign oneshot = '0;
`endif

  // Handshake: a request transfers on a clk_in edge where cfg_valid && cfg_ready;
  // cfg_ready stays low while a validated request waits for its channel to wrap.
  assign cfg_ready = (state_q == ST_IDLE);
  assign cfg_err   = err_q;
  assign tick      = tick_q;
  assign clk_out   = clk_q;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      wrap[i] = (cnt_q[i] == div_q[i] - 1'b1);
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_ch_d  = pend_ch_q;
    pend_div_d = pend_div_q;
    err_d      = 1'b0;
    apply_ch   = '0;
    // A stopped or disabled channel has no period in flight, so it may take D at once.
    for (int i = 0; i < CHANNELS; i++) begin
      if (state_q == ST_PEND && pend_ch_q == CH_W'(i)) begin
        apply_ch[i] = sync | ~ch_en[i] | done_q[i] | wrap[i];
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (cfg_div < CNT_W'(2) || {1'b0, cfg_ch} >= CH_LIM) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_PEND;
            pend_ch_d  = cfg_ch;
            pend_div_d = cfg_div;
          end
        end
      end
      default: begin
        if (|apply_ch) state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i]  = cnt_q[i];
      div_d[i]  = apply_ch[i] ? pend_div_q : div_q[i];
      tick_d[i] = 1'b0;
      clk_d[i]  = 1'b0;
      done_d[i] = done_q[i];
      if (sync || !ch_en[i]) begin
        cnt_d[i]  = '0;
        done_d[i] = 1'b0;
      end else if (done_q[i]) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i]  = wrap[i] ? '0 : cnt_q[i] + 1'b1;
        tick_d[i] = wrap[i];
        clk_d[i]  = (cnt_q[i] < (div_q[i] >> 1));
        if (oneshot[i] && wrap[i]) done_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_ch_q  <= '0;
      pend_div_q <= '0;
      err_q      <= 1'b0;
      tick_q     <= '0;
      clk_q      <= '0;
      done_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= RESET_DIV_W;
      end
    end else begin
      state_q    <= state_d;
      pend_ch_q  <= pend_ch_d;
      pend_div_q <= pend_div_d;
      err_q      <= err_d;
      tick_q     <= tick_d;
      clk_q      <= clk_d;
      done_q     <= done_d;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
    end
  end

endmodule

// File: tb/tb_prescaler_prog.sv
// Bench for prescaler_prog: directed scenarios then random traffic against a
// period-position reference model; expected outputs go through a queue to a monitor.
module tb_prescaler_prog;
  localparam int CH = 3;
  localparam int CW = 16;
  localparam int RD = 4;
  localparam int W  = 2 * CH + 2;

  logic          clk_in = 1'b0;
  logic          rst, sync, cfg_valid, cfg_ready, cfg_err;
  logic [CH-1:0] ch_en, tick, clk_out, oneshot;
  logic [1:0]    cfg_ch;
  logic [CW-1:0] cfg_div;

  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: position within the current period and the period length.
  int            m_d [CH];
  int            m_el[CH];
  bit            m_stop[CH];
  bit            m_pend;
  int            m_pch, m_pdiv;
  logic [CH-1:0] m_tick, m_clk;
  logic          m_err;

  prescaler_prog #(.MAIN_CLOCK(RD * 1000), .CHANNELS(CH), .CNT_W(CW)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .ch_en     (ch_en),
`ifdef PRESCALER_ONESHOT_EN
    .ch_oneshot(oneshot),
`endif
    .sync      (sync),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .tick      (tick),
    .clk_out   (clk_out)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  // Predict the outputs the coming edge will produce from the inputs now applied.
  task automatic model_step();
    int k;
    int ap;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_d[i] = RD; m_el[i] = 0; m_stop[i] = 0;
      end
      m_tick = '0; m_clk = '0; m_pend = 0; m_err = 0;
      return;
    end
    m_err = 0;
    ap = -1;
    if (m_pend) begin
      if (sync || !ch_en[m_pch] || m_stop[m_pch] || (m_el[m_pch] + 1 == m_d[m_pch])) ap = m_pch;
    end else if (cfg_valid) begin
      if (cfg_div < 2 || int'(cfg_ch) >= CH) m_err = 1;
      else begin
        m_pend = 1; m_pch = int'(cfg_ch); m_pdiv = int'(cfg_div);
      end
    end
    for (int i = 0; i < CH; i++) begin
      k = m_el[i] + 1;
      if (sync || !ch_en[i]) begin
        m_el[i] = 0; m_tick[i] = 0; m_clk[i] = 0; m_stop[i] = 0;
      end else if (m_stop[i]) begin
        m_el[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
      end else begin
        m_tick[i] = (k == m_d[i]);
        m_clk[i]  = (k <= m_d[i] / 2);
        m_el[i]   = (k == m_d[i]) ? 0 : k;
        if (oneshot[i] && k == m_d[i]) m_stop[i] = 1;
      end
    end
    if (ap >= 0) begin
      m_d[ap] = m_pdiv;
      m_pend  = 0;
    end
  endtask

  // Driver: inputs are already set; record the prediction and advance one cycle.
  task automatic step();
    model_step();
    exp_q.push_back({m_tick, m_clk, ~m_pend, m_err});
    @(negedge clk_in);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send_cfg(input int ch, input int div);
    for (int g = 0; g < 100 && m_pend; g++) step();
    if (m_pend) begin
      n_err++;
      $display("FAIL cfg_wait: cfg slot still busy after 100 cycles, required free");
    end
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = CW'(div);
    step();
    cfg_valid = 1'b0;
  endtask

  // Scoreboard monitor
  initial begin
    logic [W-1:0] exp_v, got_v;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        got_v = {tick, clk_out, cfg_ready, cfg_err};
        n_vec++;
        if (got_v !== exp_v) begin
          n_err++;
          $display("FAIL outputs t=%0t: got tick=%b clk_out=%b ready=%b err=%b, required tick=%b clk_out=%b ready=%b err=%b",
                   $time, got_v[W-1 -: CH], got_v[CH+1 -: CH], got_v[1], got_v[0],
                   exp_v[W-1 -: CH], exp_v[CH+1 -: CH], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; sync = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;
    ch_en = '0; oneshot = '0;
    run(2);
    rst = 1'b0; ch_en = '1;
    run(20);

    // Reprogram ch0 to 6 while it sits at count 1.
    for (int g = 0; g < 20 && m_el[0] != 1; g++) step();
    send_cfg(0, 6);
    run(14);

    // Rejected requests.
    send_cfg(0, 1);
    run(3);
    send_cfg(CH, 5);
    run(3);

    // Out-of-phase channels, then sync.
    send_cfg(1, 6);
    run(9);
    sync = 1'b1; step(); sync = 1'b0;
    run(14);

    // Odd divisor, disable mid-period, re-enable.
    send_cfg(2, 5);
    run(8);
    ch_en[2] = 1'b0; run(2);
    ch_en[2] = 1'b1; run(8);

    // Config in the same cycle as sync.
    sync = 1'b1; send_cfg(1, 3); sync = 1'b0;
    run(10);

`ifdef PRESCALER_ONESHOT_EN
    send_cfg(0, 3);
    oneshot = 3'b001;
    sync = 1'b1; step(); sync = 1'b0;
    run(30);
    sync = 1'b1; step(); sync = 1'b0;
    run(6);
    oneshot = '0;
`endif

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) ch_en[$urandom_range(0, CH - 1)] ^= 1'b1;
      sync      = ($urandom_range(0, 49) == 0);
      cfg_valid = ($urandom_range(0, 5) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_div   = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 1)) : CW'($urandom_range(2, 9));
`ifdef PRESCALER_ONESHOT_EN
      if ($urandom_range(0, 99) == 0) oneshot = CH'($urandom);
`endif
      step();
    end
    rst = 1'b0; sync = 1'b0; cfg_valid = 1'b0;
    run(4);

    repeat (2) @(posedge clk_in);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
